// File: rtl/intr_pkg.sv
// Shared constants for the interrupt sequencer: source slots, exception codes,
// MSR bit positions (big-endian numbering) and FSM state encoding.
package intr_pkg;

  localparam int NUM_SRC = 8;

  localparam int SRC_DSI  = 0;
  localparam int SRC_ISI  = 1;
  localparam int SRC_ITLB = 2;
  localparam int SRC_DTLB = 3;
  localparam int SRC_DEV0 = 4;
  localparam int SRC_DEV1 = 5;
  localparam int SRC_PROG = 6;
  localparam int SRC_SC   = 7;

  localparam logic [3:0] EXC_DEV0 = 4'd0;
  localparam logic [3:0] EXC_DSI  = 4'd2;
  localparam logic [3:0] EXC_ISI  = 4'd3;
  localparam logic [3:0] EXC_DEV1 = 4'd4;
  localparam logic [3:0] EXC_PROG = 4'd6;
  localparam logic [3:0] EXC_SC   = 4'd8;
  localparam logic [3:0] EXC_DTLB = 4'd13;
  localparam logic [3:0] EXC_ITLB = 4'd14;

  // Bit indices into an MSR declared [0:31]
  localparam int MSR_CE = 14;
  localparam int MSR_EE = 16;
  localparam int MSR_PR = 17;

  localparam logic [31:0] MSR_ENTRY_MASK = 32'h0002_C000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SAVE,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational gated priority encoder: masks DEV0/DEV1 by MSR CE/EE and picks
// the highest-priority remaining request as code plus one-hot winner.
module intr_prio_enc
  import intr_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [0:31]        i_msr,
  output logic               o_any,
  output logic [3:0]         o_code,
  output logic [NUM_SRC-1:0] o_win
);

  logic [NUM_SRC-1:0] w_gated;
  logic               w_unused_msr;

  assign w_unused_msr = ^{i_msr[0:13], i_msr[15], i_msr[17:31]};

  always_comb begin
    w_gated           = i_req;
    w_gated[SRC_DEV0] = i_req[SRC_DEV0] & i_msr[MSR_CE];
    w_gated[SRC_DEV1] = i_req[SRC_DEV1] & i_msr[MSR_EE];
  end

  // Highest first: ITLB, ISI, PROG, SC, DTLB, DSI, DEV0, DEV1
  always_comb begin
    o_any  = |w_gated;
    o_code = EXC_DEV0;
    o_win  = '0;
    if (w_gated[SRC_ITLB]) begin
      o_code = EXC_ITLB;
      o_win[SRC_ITLB] = 1'b1;
    end else if (w_gated[SRC_ISI]) begin
      o_code = EXC_ISI;
      o_win[SRC_ISI] = 1'b1;
    end else if (w_gated[SRC_PROG]) begin
      o_code = EXC_PROG;
      o_win[SRC_PROG] = 1'b1;
    end else if (w_gated[SRC_SC]) begin
      o_code = EXC_SC;
      o_win[SRC_SC] = 1'b1;
    end else if (w_gated[SRC_DTLB]) begin
      o_code = EXC_DTLB;
      o_win[SRC_DTLB] = 1'b1;
    end else if (w_gated[SRC_DSI]) begin
      o_code = EXC_DSI;
      o_win[SRC_DSI] = 1'b1;
    end else if (w_gated[SRC_DEV0]) begin
      o_code = EXC_DEV0;
      o_win[SRC_DEV0] = 1'b1;
    end else if (w_gated[SRC_DEV1]) begin
      o_code = EXC_DEV1;
      o_win[SRC_DEV1] = 1'b1;
    end
  end

endmodule

// File: rtl/intr_sequencer.sv
// Interrupt entry sequencer: arbitrates exception sources, presents the winner
// to the CU, then emits the SRR0/SRR1/MSR save strobes and the source ack.
module intr_sequencer
  import intr_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_dsi_req,
  input  logic            i_isi_req,
  input  logic            i_itlb_req,
  input  logic            i_dtlb_req,
  input  logic            i_dev0_req,
  input  logic            i_dev1_req,
  input  logic            i_prog_err_req,
  input  logic            i_sc_req,
  output logic            o_dsi_ack,
  output logic            o_isi_ack,
  output logic            o_itlb_ack,
  output logic            o_dtlb_ack,
  output logic            o_dev0_ack,
  output logic            o_dev1_ack,
  output logic            o_prog_err_ack,
  output logic            o_sc_ack,
  input  logic [0:31]     i_msr,
  input  logic [PC_W-1:0] i_ivpr,
  output logic [3:0]      o_ivor_idx,
  input  logic [PC_W-1:0] i_ivor_rd,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_excep_valid,
  output logic [3:0]      o_excep_code,
  output logic [PC_W-1:0] o_intr_entry_addr,
  input  logic            i_cu_ack,
  output logic            o_srr0_wr,
  output logic            o_srr1_wr,
  output logic            o_msr_wr,
  output logic [PC_W-1:0] o_srr0_wd,
  output logic [31:0]     o_srr1_wd,
  output logic [31:0]     o_msr_wd,
  output logic            o_busy
);

  state_e             r_state;
  state_e             w_next;
  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_win;
  logic [NUM_SRC-1:0] r_win;
  logic [NUM_SRC-1:0] w_ack;
  logic               w_any;
  logic [3:0]         w_code;
  logic [3:0]         r_code;
  logic [PC_W-1:0]    r_pc;
  logic               w_save;
  logic               w_unused;

  assign w_req = {i_sc_req, i_prog_err_req, i_dev1_req, i_dev0_req,
                  i_dtlb_req, i_itlb_req, i_isi_req, i_dsi_req};

  assign w_unused = ^{i_ivpr[15:0], i_ivor_rd[PC_W-1:16], i_ivor_rd[3:0]};

  intr_prio_enc u_prio_enc (
    .i_req  (w_req),
    .i_msr  (i_msr),
    .o_any  (w_any),
    .o_code (w_code),
    .o_win  (w_win)
  );

  // Winner and pc are captured only on the IDLE->REQ transition so later
  // requests or pc changes cannot disturb an exception already in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
      r_win   <= '0;
      r_pc    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_any) begin
        r_code <= w_code;
        r_win  <= w_win;
        r_pc   <= i_pc;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_any) w_next = ST_REQ;
      ST_REQ:     if (i_cu_ack) w_next = ST_SAVE;
      ST_SAVE:    w_next = ST_RELEASE;
      ST_RELEASE: if ((w_req & r_win) == '0) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  assign w_save = (r_state == ST_SAVE);
  assign w_ack  = w_save ? r_win : '0;

  assign {o_sc_ack, o_prog_err_ack, o_dev1_ack, o_dev0_ack,
          o_dtlb_ack, o_itlb_ack, o_isi_ack, o_dsi_ack} = w_ack;

  assign o_busy        = (r_state != ST_IDLE);
  assign o_excep_valid = (r_state == ST_REQ);
  assign o_excep_code  = r_code;
  assign o_ivor_idx    = r_code;

  assign o_intr_entry_addr = o_excep_valid ?
                             {i_ivpr[PC_W-1:16], i_ivor_rd[15:4], 4'b0000} : '0;

  // System call returns past the sc instruction; everything else re-executes
  assign o_srr0_wr = w_save;
  assign o_srr1_wr = w_save;
  assign o_msr_wr  = w_save;
  assign o_srr0_wd = !w_save ? '0 :
                     (r_code == EXC_SC) ? r_pc + PC_W'(4) : r_pc;
  assign o_srr1_wd = w_save ? i_msr : '0;
  assign o_msr_wd  = w_save ? (i_msr & ~MSR_ENTRY_MASK) : '0;

endmodule

// File: tb/tb_intr_sequencer.sv
// Scoreboard bench for intr_sequencer: a priority/gating model predicts each
// entry; a negedge monitor checks whatever the DUT presents against the queue.
module tb_intr_sequencer;

  localparam int S_DSI = 0, S_ISI = 1, S_ITLB = 2, S_DTLB = 3;
  localparam int S_DEV0 = 4, S_DEV1 = 5, S_PROG = 6, S_SC = 7;

  int prio [8] = '{S_ITLB, S_ISI, S_PROG, S_SC, S_DTLB, S_DSI, S_DEV0, S_DEV1};
  int codeOf [8] = '{2, 3, 14, 13, 0, 4, 6, 8};

  typedef struct {
    logic [3:0]  code;
    logic [31:0] entry;
    logic [31:0] srr0;
    logic [31:0] srr1;
    logic [31:0] msrwd;
    logic [7:0]  ack;
  } exp_t;

  exp_t q[$];

  logic        clk, rst_n, cuAck;
  logic [7:0]  pending;
  logic [31:0] msrV, ivprV, pcV, ivorRd;
  logic [31:0] ivorMem [16];
  logic [7:0]  ackV;
  logic [3:0]  ivorIdx, excCode;
  logic [31:0] entry, srr0Wd, srr1Wd, msrWd;
  logic        excValid, srr0Wr, srr1Wr, msrWr, busy;
  logic        dsiAck, isiAck, itlbAck, dtlbAck, dev0Ack, dev1Ack, progAck, scAck;

  int checks = 0;
  int passes = 0;
  int curWin = -1;

  assign ivorRd = ivorMem[ivorIdx];
  assign ackV = {scAck, progAck, dev1Ack, dev0Ack, dtlbAck, itlbAck, isiAck, dsiAck};

  intr_sequencer #(.PC_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_dsi_req(pending[S_DSI]), .i_isi_req(pending[S_ISI]),
    .i_itlb_req(pending[S_ITLB]), .i_dtlb_req(pending[S_DTLB]),
    .i_dev0_req(pending[S_DEV0]), .i_dev1_req(pending[S_DEV1]),
    .i_prog_err_req(pending[S_PROG]), .i_sc_req(pending[S_SC]),
    .o_dsi_ack(dsiAck), .o_isi_ack(isiAck), .o_itlb_ack(itlbAck),
    .o_dtlb_ack(dtlbAck), .o_dev0_ack(dev0Ack), .o_dev1_ack(dev1Ack),
    .o_prog_err_ack(progAck), .o_sc_ack(scAck),
    .i_msr(msrV), .i_ivpr(ivprV), .o_ivor_idx(ivorIdx), .i_ivor_rd(ivorRd),
    .i_pc(pcV), .o_excep_valid(excValid), .o_excep_code(excCode),
    .o_intr_entry_addr(entry), .i_cu_ack(cuAck),
    .o_srr0_wr(srr0Wr), .o_srr1_wr(srr1Wr), .o_msr_wr(msrWr),
    .o_srr0_wd(srr0Wd), .o_srr1_wd(srr1Wd), .o_msr_wd(msrWd), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Highest-priority pending source allowed by CE (0x20000) / EE (0x8000)
  function automatic int predict(input logic [7:0] pend, input logic [31:0] m);
    for (int i = 0; i < 8; i++) begin
      int s = prio[i];
      if (!pend[s]) continue;
      if (s == S_DEV0 && !m[17]) continue;
      if (s == S_DEV1 && !m[15]) continue;
      return s;
    end
    return -1;
  endfunction

  task automatic startNext();
    exp_t e;
    curWin = predict(pending, msrV);
    if (curWin >= 0) begin
      e.code  = 4'(codeOf[curWin]);
      e.entry = {ivprV[31:16], ivorMem[e.code][15:4], 4'h0};
      e.srr0  = pcV + ((curWin == S_SC) ? 32'd4 : 32'd0);
      e.srr1  = msrV;
      e.msrwd = msrV & ~32'h0002_C000;
      e.ack   = 8'(1) << curWin;
      q.push_back(e);
    end
  endtask

  task automatic waitValid();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (excValid) break;
    end
    check("excep_valid arrival", 32'(excValid), 32'd1);
  endtask

  task automatic checkQuiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cuAck = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("quiet valid/busy", {30'd0, excValid, busy}, 32'd0);
    end
    @(posedge clk); #1;
    cuAck = 1'b0;
  endtask

  task automatic applyStimulus(input int cuDelay, input int hold, input bit pcJitter,
                               input logic [7:0] midAdd, input logic [7:0] adds,
                               input logic [31:0] nextMsr);
    logic [7:0] wb;
    wb = 8'(1) << curWin;
    waitValid();
    for (int d = 0; d < cuDelay; d++) begin
      @(posedge clk); #1;
      if (d == cuDelay / 2) pending = pending | (midAdd & ~wb);
      if (pcJitter) pcV = $urandom & ~32'h3;
    end
    @(posedge clk); #1;
    cuAck = 1'b1;
    @(posedge clk); #1;
    cuAck = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("busy through save/release", 32'(busy), 32'd1);
      @(posedge clk); #1;
      cuAck = 1'($urandom_range(0, 1));
    end
    cuAck   = 1'b0;
    pending = (pending & ~wb) | (adds & ~wb);
    msrV    = nextMsr;
    pcV     = $urandom & ~32'h3;
    ivprV   = $urandom & 32'hFFFF_0000;
    startNext();
    @(posedge clk);
    @(negedge clk);
    check("idle after release", 32'(busy), 32'd0);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " flags"}, {21'd0, excValid, busy, srr0Wr, srr1Wr, msrWr, ackV}, 32'd0);
    check({tag, " code/idx"}, {24'd0, excCode, ivorIdx}, 32'd0);
    check({tag, " entry"}, entry, 32'd0);
    check({tag, " srr0_wd"}, srr0Wd, 32'd0);
    check({tag, " srr1_wd"}, srr1Wd, 32'd0);
    check({tag, " msr_wd"}, msrWd, 32'd0);
  endtask

  // Monitor: compares every REQ cycle and every save cycle against the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (excValid) begin
        if (q.size() == 0) check("unexpected excep_valid", 32'd1, 32'd0);
        else begin
          check("excep_code", 32'(excCode), 32'(q[0].code));
          check("ivor_idx", 32'(ivorIdx), 32'(q[0].code));
          check("intr_entry_addr", entry, q[0].entry);
          check("busy in REQ", 32'(busy), 32'd1);
        end
      end
      if (srr0Wr) begin
        if (q.size() == 0) check("unexpected save", 32'd1, 32'd0);
        else begin
          check("srr0_wd", srr0Wd, q[0].srr0);
          check("srr1_wd", srr1Wd, q[0].srr1);
          check("msr_wd", msrWd, q[0].msrwd);
          check("ack one-hot", 32'(ackV), 32'(q[0].ack));
          check("srr1/msr strobes", {30'd0, srr1Wr, msrWr}, 32'd3);
          void'(q.pop_front());
        end
      end else if (ackV != 8'd0 || srr1Wr || msrWr) begin
        check("stray ack/strobe", {22'd0, srr1Wr, msrWr, ackV}, 32'd0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cuAck = 1'b0; pending = 8'd0;
    msrV = 32'd0; ivprV = 32'd0; pcV = 32'd0;
    for (int i = 0; i < 16; i++) ivorMem[i] = $urandom;
    ivorMem[8] = 32'h0000_0080;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    rst_n = 1'b1;

    // System call with known addresses
    @(posedge clk); #1;
    msrV = 32'h0000_C000; ivprV = 32'hFFFF_0000; pcV = 32'h0000_0100;
    pending = 8'(1) << S_SC;
    startNext();
    applyStimulus(2, 1, 1'b0, 8'd0, 8'd0, 32'h0000_C000);

    // Simultaneous ITLB, DSI, SC served in priority order
    @(posedge clk); #1;
    pending = (8'(1) << S_ITLB) | (8'(1) << S_DSI) | (8'(1) << S_SC);
    startNext();
    while (curWin >= 0) applyStimulus(1, 1, 1'b0, 8'd0, 8'd0, 32'h0000_C000);

    // Gating: DEV1 blocked until EE, DEV0 blocked while CE clear
    @(posedge clk); #1;
    msrV = 32'h0000_4000;
    pending = (8'(1) << S_DEV1) | (8'(1) << S_DEV0);
    startNext();
    checkQuiet(20);
    msrV = 32'h0000_8000;
    startNext();
    applyStimulus(1, 1, 1'b0, 8'd0, 8'd0, 32'h0000_8000);
    checkQuiet(10);
    pending = 8'd0;

    // Long cu_ack wait with a higher-priority arrival, then a slow release
    @(posedge clk); #1;
    msrV = 32'h0000_C000;
    pending = 8'(1) << S_DSI;
    startNext();
    applyStimulus(10, 1, 1'b1, 8'(1) << S_ISI, 8'd0, 32'h0000_C000);
    applyStimulus(0, 4, 1'b0, 8'd0, 8'd0, 32'h0000_C000);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      if (curWin < 0) begin
        int pick [6] = '{S_DSI, S_ISI, S_ITLB, S_DTLB, S_PROG, S_SC};
        checkQuiet(2);
        pending = pending | (8'(1) << pick[$urandom_range(0, 5)]);
        startNext();
      end
      applyStimulus($urandom_range(0, 4), $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                    8'(1) << $urandom_range(0, 7), 8'($urandom & $urandom), $urandom);
    end

    // Reset in the middle of REQ, then restart from IDLE
    if (curWin < 0) begin
      @(posedge clk); #1;
      pending = pending | (8'(1) << S_PROG);
      startNext();
    end
    waitValid();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset");
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    startNext();
    applyStimulus(1, 1, 1'b0, 8'd0, 8'd0, 32'h0002_C000);

    // Drain everything still pending with all sources enabled
    @(posedge clk); #1;
    msrV = 32'h0002_C000;
    if (curWin < 0) startNext();
    for (int k = 0; k < 10 && curWin >= 0; k++)
      applyStimulus(0, 1, 1'b0, 8'd0, 8'd0, 32'h0002_C000);
    check("scoreboard drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
